gpio_mux_cfg_seq: RTL and testbench

Bus-master sequencer that owns all writes to one gpio_mux pin-control register (64-bit control, 2 bits per pin, low word at base address, high word at base address + 1). Multiple on-chip requesters ask for "pin P -> function F". The block arbitrates between them round-robin, wins the peripheral bus from the system bus arbiter, and performs a read-modify-write of the correct control word. Only the selected 2-bit field changes; the other 15 pin fields in that word are preserved.

---
 rtl/gpio_cfg_pkg.sv | 15 +
 rtl/gpio_mux_cfg_seq_rr_arbiter.sv | 25 ++
 rtl/gpio_mux_cfg_seq.sv | 133 +++++++++++++
 tb/tb_gpio_mux_cfg_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared state encoding and field geometry for the gpio_mux config sequencer
package gpio_cfg_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSREQ,
        S_RD,
        S_RDWAIT,
        S_WR,
        S_DONE
    } state_t;
    localparam int PIN_W        = 5;
    localparam int FUNC_W       = 2;
    localparam int FIELD_W      = 2;
    localparam int WORD_SEL_BIT = 4;
endpackage

// File: rtl/gpio_mux_cfg_seq_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW-1:0] cand;
    // Scan from farthest to nearest after the pointer so the nearest active requester wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (req_i[cand]) begin
                gnt_o = NREQ'(1) << cand;
                idx_o = cand;
            end
        end
    end
endmodule

// File: rtl/gpio_mux_cfg_seq.sv
// gpio_mux_cfg_seq: round-robin read-modify-write sequencer for the gpio_mux pin-control register
module gpio_mux_cfg_seq
    import gpio_cfg_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter bit SKIP_SAME = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*PIN_W-1:0]  req_pin,
    input  logic [NREQ*FUNC_W-1:0] req_func,
    output logic [NREQ-1:0]        ack,
    input  logic [31:0]            base_addr,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic [31:0]            sys_r_addr,
    output logic                   sys_r,
    input  logic [31:0]            sys_r_line,
    output logic [31:0]            sys_w_addr,
    output logic [31:0]            sys_w_line,
    output logic                   sys_w,
    output logic                   busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] FMASK = 32'((1 << FIELD_W) - 1);

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt_oh;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   ack_q;
    logic [PIN_W-1:0]  pin_q;
    logic [FUNC_W-1:0] func_q;
    logic              bus_req_q;
    logic              sys_r_q;
    logic              sys_w_q;
    logic              busy_q;
    logic [31:0]       sys_r_addr_q;
    logic [31:0]       sys_w_addr_q;
    logic [31:0]       sys_w_line_q;
    logic [31:0]       addr_d;
    logic [31:0]       word_d;
    logic              same_d;
    int                sh;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx)
    );

    // Word address for the latched pin, the merged write-back word and the already-equal test
    always_comb begin
        sh     = FIELD_W * int'(pin_q[WORD_SEL_BIT-1:0]);
        addr_d = base_addr | 32'(pin_q[WORD_SEL_BIT]);
        word_d = (sys_r_line & ~(FMASK << sh)) | (32'(func_q) << sh);
        same_d = FUNC_W'(sys_r_line >> sh) == func_q;
    end

    // Sequencer: arbitrate, own the bus, read the control word, write back the merged field, ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= IW'(NREQ - 1);
            grant_q      <= '0;
            ack_q        <= '0;
            pin_q        <= '0;
            func_q       <= '0;
            bus_req_q    <= 1'b0;
            sys_r_q      <= 1'b0;
            sys_w_q      <= 1'b0;
            busy_q       <= 1'b0;
            sys_r_addr_q <= '0;
            sys_w_addr_q <= '0;
            sys_w_line_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (|req) begin
                    state_q   <= S_BUSREQ;
                    ptr_q     <= gnt_idx;
                    grant_q   <= gnt_oh;
                    pin_q     <= PIN_W'(req_pin >> (PIN_W * int'(gnt_idx)));
                    func_q    <= FUNC_W'(req_func >> (FUNC_W * int'(gnt_idx)));
                    bus_req_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                S_BUSREQ: if (bus_gnt) begin
                    state_q      <= S_RD;
                    sys_r_q      <= 1'b1;
                    sys_r_addr_q <= addr_d;
                end
                S_RD: begin
                    state_q <= S_RDWAIT;
                    sys_r_q <= 1'b0;
                end
                S_RDWAIT: if (SKIP_SAME && same_d) begin
                    state_q   <= S_DONE;
                    bus_req_q <= 1'b0;
                    ack_q     <= grant_q;
                end else begin
                    state_q      <= S_WR;
                    sys_w_q      <= 1'b1;
                    sys_w_addr_q <= sys_r_addr_q;
                    sys_w_line_q <= word_d;
                end
                S_WR: begin
                    state_q   <= S_DONE;
                    sys_w_q   <= 1'b0;
                    bus_req_q <= 1'b0;
                    ack_q     <= grant_q;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign bus_req    = bus_req_q;
    assign sys_r      = sys_r_q;
    assign sys_w      = sys_w_q;
    assign busy       = busy_q;
    assign sys_r_addr = sys_r_addr_q;
    assign sys_w_addr = sys_w_addr_q;
    assign sys_w_line = sys_w_line_q;
endmodule

// File: tb/tb_gpio_mux_cfg_seq.sv
// tb_gpio_mux_cfg_seq: randomized self-checking bench with a word-level slave and field model
module tb_gpio_mux_cfg_seq;
  localparam int NREQ = 2;
  localparam logic [31:0] BASE = 32'h100;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*5-1:0] req_pin = '0;
  logic [NREQ*2-1:0] req_func = '0;
  logic [NREQ-1:0] ack;
  logic [31:0]     base_addr = BASE;
  logic            bus_req;
  logic            bus_gnt = 1'b1;
  logic            sys_r;
  logic            sys_w;
  logic            busy;
  logic [31:0]     sys_r_addr;
  logic [31:0]     sys_w_addr;
  logic [31:0]     sys_w_line;
  logic [31:0]     sys_r_line = '0;
  logic [31:0] mem [2];
  logic [31:0] exp_mem [2];
  logic        ld = 1'b0;
  int          ld_w = 0;
  logic [31:0] ld_v = '0;
  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int ack_cnt [NREQ];
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  gpio_mux_cfg_seq #(.NREQ(NREQ), .SKIP_SAME(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_pin    (req_pin),
    .req_func   (req_func),
    .ack        (ack),
    .base_addr  (base_addr),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .sys_r_addr (sys_r_addr),
    .sys_r      (sys_r),
    .sys_r_line (sys_r_line),
    .sys_w_addr (sys_w_addr),
    .sys_w_line (sys_w_line),
    .sys_w      (sys_w),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) mem[ld_w] <= ld_v;
    if (sys_r) sys_r_line <= mem[(sys_r_addr == BASE + 32'd1) ? 1 : 0];
    if (sys_w) mem[(sys_w_addr == BASE + 32'd1) ? 1 : 0] <= sys_w_line;
  end

  always @(negedge clk) begin
    if (sys_r) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= sys_r_addr;
    end
    if (sys_w) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= sys_w_addr;
      last_wdata <= sys_w_line;
    end
    for (int k = 0; k < NREQ; k++) if (ack[k]) ack_cnt[k] <= ack_cnt[k] + 1;
  end

  function automatic int field(input logic [31:0] w, input int pin);
    return int'((w >> (2 * (pin % 16))) & 32'd3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input int pin, input int func);
    int s;
    s = 2 * (pin % 16);
    return old - (32'(field(old, pin)) << s) + (32'(func) << s);
  endfunction

  function automatic int rr_next(input int last, input logic [NREQ-1:0] pend);
    for (int i = 1; i <= NREQ; i++) if (pend[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preset(input int w, input logic [31:0] v);
    ld_w = w;
    ld_v = v;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    exp_mem[w] = v;
  endtask

  task automatic issue(input int k, input int pin, input int func, output int lat);
    req_pin[k*5 +: 5]  = 5'(pin);
    req_func[k*2 +: 2] = 2'(func);
    req[k] = 1'b1;
    lat = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (ack[k]) break;
    end
    if (!ack[k]) lat = -1;
    req[k] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({ack, bus_req, sys_r, sys_w, busy} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got ack=%b bus_req=%b sys_r=%b sys_w=%b busy=%b want all 0", ack, bus_req, sys_r, sys_w, busy);
    end
    tests++;
    if (sys_r_addr !== 0 || sys_w_addr !== 0 || sys_w_line !== 0) begin
      fails++;
      $display("FAIL reset_data: got r_addr=%h w_addr=%h w_line=%h want 0", sys_r_addr, sys_w_addr, sys_w_line);
    end
    rst = 1'b1;
    tick();
    preset(0, 32'h0);
    preset(1, 32'h0);
  endtask

  task automatic test_low_word();
    int lat, r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    issue(0, 3, 2, lat);
    exp_mem[0] = merge(exp_mem[0], 3, 2);
    tests++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL low_word_latency: got %0d want 5", lat);
    end
    tests++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
      fails++;
      $display("FAIL low_word_strobes: got rd=%0d wr=%0d want 1 1", rd_cnt - r0, wr_cnt - w0);
    end
    tests++;
    if (last_raddr !== BASE || last_waddr !== BASE) begin
      fails++;
      $display("FAIL low_word_addr: got r=%h w=%h want %h", last_raddr, last_waddr, BASE);
    end
    tests++;
    if (last_wdata !== 32'h80) begin
      fails++;
      $display("FAIL low_word_data: got %h want 00000080", last_wdata);
    end
    tests++;
    if (ack !== '0) begin
      fails++;
      $display("FAIL low_word_ack_pulse: got %b want 0", ack);
    end
  endtask

  task automatic test_high_word();
    int lat, a0;
    preset(1, 32'h1);
    a0 = ack_cnt[0];
    issue(1, 17, 3, lat);
    exp_mem[1] = merge(exp_mem[1], 17, 3);
    tests++;
    if (last_raddr !== BASE + 32'd1 || last_waddr !== BASE + 32'd1) begin
      fails++;
      $display("FAIL high_word_addr: got r=%h w=%h want %h", last_raddr, last_waddr, BASE + 32'd1);
    end
    tests++;
    if (last_wdata !== 32'hD) begin
      fails++;
      $display("FAIL high_word_data: got %h want 0000000d", last_wdata);
    end
    tests++;
    if (ack_cnt[0] !== a0 || lat !== 5) begin
      fails++;
      $display("FAIL high_word_ack: got ack0 pulses=%0d lat=%0d want 0 and 5", ack_cnt[0] - a0, lat);
    end
    tests++;
    if (mem[1] !== exp_mem[1]) begin
      fails++;
      $display("FAIL high_word_mem: got %h want %h", mem[1], exp_mem[1]);
    end
  endtask

  task automatic test_skip_same();
    int lat, r0, w0;
    preset(0, 32'h80);
    r0 = rd_cnt;
    w0 = wr_cnt;
    issue(0, 3, 2, lat);
    tests++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
      fails++;
      $display("FAIL skip_strobes: got rd=%0d wr=%0d want 1 0", rd_cnt - r0, wr_cnt - w0);
    end
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL skip_latency: got %0d want 4", lat);
    end
  endtask

  task automatic test_bus_wait();
    int r0, bad, lat;
    bus_gnt = 1'b0;
    r0 = rd_cnt;
    bad = 0;
    req_pin[4:0] = 5'd5;
    req_func[1:0] = 2'd1;
    req[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(bus_req === 1'b1 && busy === 1'b1 && rd_cnt == r0)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bus_wait_hold: got %0d bad cycles want 0", bad);
    end
    bus_gnt = 1'b1;
    tick();
    tests++;
    if (sys_r !== 1'b1) begin
      fails++;
      $display("FAIL bus_wait_read: got sys_r=%b want 1", sys_r);
    end
    lat = 0;
    while (lat < 20 && ack[0] !== 1'b1) begin
      tick();
      lat++;
    end
    req[0] = 1'b0;
    tick();
    exp_mem[0] = merge(exp_mem[0], 5, 1);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL bus_wait_done: got %0d cycles want 3", lat);
    end
    tests++;
    if (mem[0] !== exp_mem[0]) begin
      fails++;
      $display("FAIL bus_wait_mem: got %h want %h", mem[0], exp_mem[0]);
    end
  endtask

  task automatic test_round_robin();
    int last, exp_k, budget;
    logic [NREQ-1:0] pend;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    last = NREQ - 1;
    req_pin = {5'd20, 5'd1};
    req_func = {2'd1, 2'd3};
    for (int round = 0; round < 2; round++) begin
      pend = '1;
      req = '1;
      budget = 0;
      while (pend != 0 && budget < 60) begin
        tick();
        budget++;
        if (ack != 0) begin
          exp_k = rr_next(last, pend);
          tests++;
          if (ack !== NREQ'(1) << exp_k) begin
            fails++;
            $display("FAIL rr_order round %0d: got ack=%b want requester %0d", round, ack, exp_k);
          end
          last = exp_k;
          pend = pend & ~ack;
          req = req & ~ack;
        end
      end
      tests++;
      if (pend != 0) begin
        fails++;
        $display("FAIL rr_timeout round %0d: got pending=%b want 0", round, pend);
      end
      req = '0;
      tick();
    end
    exp_mem[0] = merge(exp_mem[0], 1, 3);
    exp_mem[1] = merge(exp_mem[1], 20, 1);
    tests++;
    if (mem[0] !== exp_mem[0] || mem[1] !== exp_mem[1]) begin
      fails++;
      $display("FAIL rr_mem: got %h %h want %h %h", mem[0], mem[1], exp_mem[0], exp_mem[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    int wt, w0, a0, budget;
    req_pin[4:0] = 5'd2;
    req_func[1:0] = 2'd3;
    req[0] = 1'b1;
    wt = 0;
    while (sys_r !== 1'b1 && wt < 20) begin
      tick();
      wt++;
    end
    tests++;
    if (sys_r !== 1'b1) begin
      fails++;
      $display("FAIL midrst_reach_read: got sys_r=%b want 1", sys_r);
    end
    tick();
    w0 = wr_cnt;
    a0 = ack_cnt[0];
    rst = 1'b0;
    #1;
    tests++;
    if ({ack, bus_req, sys_r, sys_w, busy} !== '0 || sys_r_addr !== 0 || sys_w_addr !== 0 || sys_w_line !== 0) begin
      fails++;
      $display("FAIL midrst_outputs: got ctrl=%b r_addr=%h w_addr=%h w_line=%h want all 0",
               {ack, bus_req, sys_r, sys_w, busy}, sys_r_addr, sys_w_addr, sys_w_line);
    end
    req = '0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (wr_cnt !== w0 || ack_cnt[0] !== a0) begin
      fails++;
      $display("FAIL midrst_no_commit: got writes=%0d acks=%0d want 0 0", wr_cnt - w0, ack_cnt[0] - a0);
    end
    req_pin[9:5] = 5'd30;
    req_func[3:2] = 2'd2;
    req = '1;
    budget = 0;
    while (ack == 0 && budget < 20) begin
      tick();
      budget++;
    end
    tests++;
    if (ack !== 2'b01) begin
      fails++;
      $display("FAIL midrst_pointer: got first ack=%b want 01", ack);
    end
    req[0] = 1'b0;
    budget = 0;
    while (ack[1] !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    req = '0;
    tick();
    exp_mem[0] = merge(exp_mem[0], 2, 3);
    exp_mem[1] = merge(exp_mem[1], 30, 2);
    tests++;
    if (mem[0] !== exp_mem[0] || mem[1] !== exp_mem[1]) begin
      fails++;
      $display("FAIL midrst_after: got %h %h want %h %h", mem[0], mem[1], exp_mem[0], exp_mem[1]);
    end
  endtask

  task automatic test_random();
    int k, pin, func, w, lat, r0, w0;
    bit skip;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, NREQ - 1));
      pin = int'($urandom_range(0, 31));
      w = pin / 16;
      if ($urandom_range(0, 1) == 1) preset(w, $urandom);
      func = ($urandom_range(0, 2) == 0) ? field(exp_mem[w], pin) : int'($urandom_range(0, 3));
      skip = field(exp_mem[w], pin) == func;
      r0 = rd_cnt;
      w0 = wr_cnt;
      issue(k, pin, func, lat);
      exp_mem[w] = merge(exp_mem[w], pin, func);
      tests++;
      if (lat !== (skip ? 4 : 5)) begin
        fails++;
        $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, skip ? 4 : 5);
      end
      tests++;
      if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== (skip ? 0 : 1)) begin
        fails++;
        $display("FAIL rand%0d_strobes: got rd=%0d wr=%0d want 1 %0d", n, rd_cnt - r0, wr_cnt - w0, skip ? 0 : 1);
      end
      tests++;
      if (last_raddr !== BASE + 32'(w)) begin
        fails++;
        $display("FAIL rand%0d_addr: got %h want %h", n, last_raddr, BASE + 32'(w));
      end
      tests++;
      if (mem[w] !== exp_mem[w]) begin
        fails++;
        $display("FAIL rand%0d_mem: got %h want %h", n, mem[w], exp_mem[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_low_word();
    test_high_word();
    test_skip_same();
    test_bus_wait();
    test_round_robin();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
